// File: rtl/muldiv_alu.sv
// muldiv_alu: single-cycle ALU plus iterative unsigned multiply and divide.
// Single-cycle results land in Output; MULTU/DIVU write the Hi/Lo pair after
// WIDTH iterations, one bit per clock, and are read back with MFHI/MFLO.
module muldiv_alu #(
  parameter int WIDTH  = 32,
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] Output,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [5:0] OP_AND   = 6'd36;
  localparam logic [5:0] OP_OR    = 6'd37;
  localparam logic [5:0] OP_ADD   = 6'd32;
  localparam logic [5:0] OP_SUB   = 6'd34;
  localparam logic [5:0] OP_SLT   = 6'd42;
  localparam logic [5:0] OP_SLL   = 6'd0;
  localparam logic [5:0] OP_SRL   = 6'd2;
  localparam logic [5:0] OP_DIVU  = 6'd27;
  localparam logic [5:0] OP_MULTU = 6'd25;
  localparam logic [5:0] OP_MFHI  = 6'd16;
  localparam logic [5:0] OP_MFLO  = 6'd18;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t                   state, state_nxt;
  logic [SW-1:0]            cnt;
  logic [WIDTH-1:0]         hi, lo;
  // Iteration registers: work_hi is the partial remainder / upper product,
  // work_lo the dividend-quotient / multiplier shift register, opnd the
  // divisor / multiplicand held for the whole operation.
  logic [WIDTH-1:0]         work_hi, work_lo, opnd;

  logic signed [WIDTH-1:0]  a_s, b_s;
  logic [WIDTH-1:0]         res;
  logic                     accept, is_div, is_mul, last;

  logic [WIDTH:0]           div_trial;
  logic                     div_ge;
  logic [WIDTH-1:0]         div_rem, div_q;
  logic [WIDTH:0]           mul_sum;
  logic [WIDTH-1:0]         mul_hi, mul_lo;

  assign a_s    = dataA;
  assign b_s    = dataB;
  assign busy   = (state != IDLE);
  assign accept = start && (state == IDLE);
  assign is_div = (Signal == OP_DIVU);
  assign is_mul = (MUL_EN != 0) && (Signal == OP_MULTU);
  assign last   = (cnt == SW'(WIDTH - 1));

  // Single-cycle result; unknown opcodes (and MULTU when disabled) give zero.
  always_comb begin
    res = '0;
    case (Signal)
      OP_AND:  res = dataA & dataB;
      OP_OR:   res = dataA | dataB;
      OP_ADD:  res = dataA + dataB;
      OP_SUB:  res = dataA - dataB;
      OP_SLT:  res = {{(WIDTH-1){1'b0}}, (a_s < b_s)};
      OP_SLL:  res = dataA << dataB[SW-1:0];
      OP_SRL:  res = dataA >> dataB[SW-1:0];
      OP_MFHI: res = hi;
      OP_MFLO: res = lo;
      default: res = '0;
    endcase
  end

  // One restoring-divide step and one shift-add multiply step per clock.
  // The trial subtraction is done in WIDTH bits: when it is taken the true
  // remainder is below the divisor, so the top bit is always zero.
  always_comb begin
    div_trial = {work_hi, work_lo[WIDTH-1]};
    div_ge    = (div_trial >= {1'b0, opnd});
    div_rem   = div_ge ? (div_trial[WIDTH-1:0] - opnd) : div_trial[WIDTH-1:0];
    div_q     = {work_lo[WIDTH-2:0], div_ge};
    mul_sum   = {1'b0, work_hi} + (work_lo[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
    mul_hi    = mul_sum[WIDTH:1];
    mul_lo    = {mul_sum[0], work_lo[WIDTH-1:1]};
  end

  // FSM next state: leave IDLE on an accepted multi-cycle op, return after
  // the last iteration.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_div)      state_nxt = DIV;
          else if (is_mul) state_nxt = MUL;
        end
      end
      MUL, DIV: begin
        if (last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Architectural state: Output, Hi/Lo, done pulse, sticky divide-by-zero
  // flag and iteration counter. Hi/Lo only change on the final iteration so
  // partial results are never observable.
  always_ff @(posedge clk) begin
    if (reset) begin
      Output      <= '0;
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cnt <= '0;
            if (is_div) begin
              if (dataB != '0) div_by_zero <= 1'b0;
            end else if (!is_mul) begin
              Output <= res;
              done   <= 1'b1;
            end
          end
        end
        DIV: begin
          cnt <= cnt + SW'(1);
          if (last) begin
            hi   <= div_rem;
            lo   <= div_q;
            done <= 1'b1;
            if (opnd == '0) div_by_zero <= 1'b1;
          end
        end
        MUL: begin
          cnt <= cnt + SW'(1);
          if (last) begin
            hi   <= mul_hi;
            lo   <= mul_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Iteration datapath: loaded on acceptance, stepped while busy.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (accept && is_div) begin
          work_hi <= '0;
          work_lo <= dataA;
          opnd    <= dataB;
        end else if (accept && is_mul) begin
          work_hi <= '0;
          work_lo <= dataB;
          opnd    <= dataA;
        end
      end
      DIV: begin
        work_hi <= div_rem;
        work_lo <= div_q;
      end
      MUL: begin
        work_hi <= mul_hi;
        work_lo <= mul_lo;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_muldiv_alu.sv
// Testbench for muldiv_alu (WIDTH=32): scoreboard of expected Output and
// div_by_zero values, popped on every done pulse.
module tb_muldiv_alu;

  localparam int W = 32;

  localparam logic [5:0] AND_ = 6'd36, OR_ = 6'd37, ADD = 6'd32, SUB = 6'd34,
                         SLT = 6'd42, SLL = 6'd0, SRL = 6'd2, DIVU = 6'd27,
                         MULTU = 6'd25, MFHI = 6'd16, MFLO = 6'd18;

  logic         clk = 1'b0;
  logic         reset, start;
  logic [5:0]   Signal;
  logic [W-1:0] dataA, dataB, Output;
  logic         busy, done, div_by_zero;

  always #5 clk = ~clk;

  muldiv_alu #(.WIDTH(W), .MUL_EN(1)) dut (
    .clk(clk), .reset(reset), .start(start), .Signal(Signal),
    .dataA(dataA), .dataB(dataB), .Output(Output), .busy(busy),
    .done(done), .div_by_zero(div_by_zero)
  );

  typedef struct {
    logic [5:0]   op;
    logic [W-1:0] out;
    logic         dbz;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           n_checks = 0;
  int           n_err = 0;
  int unsigned  cyc = 0;
  int unsigned  e0 = 0;
  logic [W-1:0] m_hi, m_lo, m_out;
  logic         m_dbz;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Pop and compare on every completion.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("spurious_done", {63'b0, done}, 64'd0);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("out_op%0d", mon_e.op), {32'b0, Output}, {32'b0, mon_e.out});
        check($sformatf("dbz_op%0d", mon_e.op), {63'b0, div_by_zero}, {63'b0, mon_e.dbz});
      end
    end
  end

  // Reference model, evaluated when the stimulus is driven.
  task automatic push_exp(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
    case (op)
      AND_:  m_out = a & b;
      OR_:   m_out = a | b;
      ADD:   m_out = a + b;
      SUB:   m_out = a - b;
      SLT:   m_out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      SLL:   m_out = a << b[4:0];
      SRL:   m_out = a >> b[4:0];
      MFHI:  m_out = m_hi;
      MFLO:  m_out = m_lo;
      DIVU: begin
        if (b == 0) begin
          m_lo = '1; m_hi = a; m_dbz = 1'b1;
        end else begin
          m_lo = a / b; m_hi = a % b; m_dbz = 1'b0;
        end
      end
      MULTU: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      default: m_out = '0;
    endcase
    e.op = op; e.out = m_out; e.dbz = m_dbz;
    sb.push_back(e);
  endtask

  // Drive one request across a rising edge; e0 records that edge.
  task automatic issue(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    Signal = op; dataA = a; dataB = b; start = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat, input int exp_busy);
    int bc = 0;
    forever begin
      @(negedge clk);
      if (busy) bc++;
      if (done) break;
      if (cyc - e0 > 200) begin
        check("timeout", {63'b0, done}, 64'd1);
        return;
      end
    end
    check("latency", 64'(cyc - e0), 64'(exp_lat));
    if (exp_busy >= 0) check("busy_cycles", 64'(bc), 64'(exp_busy));
  endtask

  task automatic run(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input int exp_lat, input int exp_busy);
    push_exp(op, a, b);
    issue(op, a, b);
    wait_done(exp_lat, exp_busy);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [5:0] single_ops [9] = '{AND_, OR_, ADD, SUB, SLT, SLL, SRL, MFHI, MFLO};

  initial begin
    reset = 1'b1; start = 1'b0; Signal = '0; dataA = '0; dataB = '0;
    m_hi = '0; m_lo = '0; m_out = '0; m_dbz = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_output", {32'b0, Output}, 64'd0);
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_done", {63'b0, done}, 64'd0);
    check("rst_dbz", {63'b0, div_by_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Wrap-around arithmetic, compare and shifts.
    run(ADD, 32'hFFFF_FFFF, 32'd1, 0, -1);
    run(SUB, 32'd5, 32'd7, 0, -1);
    run(SLT, 32'hFFFF_FFFF, 32'd1, 0, -1);
    run(SLT, 32'd1, 32'hFFFF_FFFF, 0, -1);
    run(SRL, 32'h8000_0000, 32'd31, 0, -1);
    run(SLL, 32'd1, 32'h21, 0, -1);
    run(AND_, 32'hF0F0_1234, 32'h0FF0_FF00, 0, -1);
    run(OR_, 32'hF000_0001, 32'h0000_0F10, 0, -1);
    run(6'd63, 32'h1234, 32'h5678, 0, -1);

    // Divide, back-to-back reads in the done cycle.
    run(DIVU, 32'd100, 32'd7, 32, 32);
    run(MFHI, 32'hDEAD, 32'hBEEF, 0, -1);
    run(MFLO, 32'd0, 32'd0, 0, -1);

    // Multiply with an ADD request issued mid-operation that must be ignored.
    push_exp(MULTU, 32'hFFFF_FFFF, 32'd2);
    issue(MULTU, 32'hFFFF_FFFF, 32'd2);
    repeat (4) @(negedge clk);
    Signal = ADD; dataA = 32'd1; dataB = 32'd1; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(32, -1);
    run(MFHI, 32'd0, 32'd0, 0, -1);
    run(MFLO, 32'd0, 32'd0, 0, -1);

    // Divide by zero, sticky across other ops, cleared by a good divide.
    run(DIVU, 32'd9, 32'd0, 32, 32);
    run(MFHI, 32'd0, 32'd0, 0, -1);
    run(MFLO, 32'd0, 32'd0, 0, -1);
    run(ADD, 32'd3, 32'd4, 0, -1);
    run(DIVU, 32'd9, 32'd3, 32, 32);
    run(MFLO, 32'd0, 32'd0, 0, -1);

    // Random single-cycle ops and multi-cycle ops.
    for (int i = 0; i < 24; i++) begin
      run(single_ops[$urandom_range(0, 8)], $urandom, $urandom, 0, -1);
    end
    for (int i = 0; i < 4; i++) begin
      run(DIVU, $urandom, (i == 3) ? 32'd0 : 32'($urandom_range(1, 1 << (8 * i + 4))), 32, 32);
      run(MFHI, 32'd0, 32'd0, 0, -1);
      run(MFLO, 32'd0, 32'd0, 0, -1);
      run(MULTU, $urandom, $urandom, 32, 32);
      run(MFHI, 32'd0, 32'd0, 0, -1);
      run(MFLO, 32'd0, 32'd0, 0, -1);
    end

    // Reset part-way through a divide: aborts with no completion.
    run(DIVU, 32'd9, 32'd0, 32, 32);
    run(MFHI, 32'd0, 32'd0, 0, -1);
    issue(DIVU, 32'd100, 32'd7);
    while (cyc < e0 + 9) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort_busy", {63'b0, busy}, 64'd0);
    check("abort_output", {32'b0, Output}, 64'd0);
    check("abort_dbz", {63'b0, div_by_zero}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    m_hi = '0; m_lo = '0; m_out = '0; m_dbz = 1'b0;
    repeat (40) @(negedge clk);
    run(MFHI, 32'd0, 32'd0, 0, -1);
    run(MFLO, 32'd0, 32'd0, 0, -1);

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
